load_wb_queue: RTL and testbench



---
 rtl/load_wb_queue_if.sv | 28 ++
 rtl/load_wb_queue.sv | 142 ++++++++++++++
 tb/tb_load_wb_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/load_wb_queue_if.sv
// Load writeback queue bus: load-result input group and CDB output slots.
// master drives load results and CDB ready; slave is the queue.
interface load_wb_queue_if #(
  parameter int unsigned NUM_LD_PORTS  = 2,
  parameter int unsigned NUM_CDB_PORTS = 1,
  parameter int unsigned RW            = 4,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic [NUM_LD_PORTS-1:0]                 in_valid;
  logic [NUM_LD_PORTS-1:0][RW-1:0]         in_rob_idx;
  logic [NUM_LD_PORTS-1:0][DATA_WIDTH-1:0] in_data;
  logic                                    in_ready;

  logic [NUM_CDB_PORTS-1:0]                 out_valid;
  logic [NUM_CDB_PORTS-1:0][RW-1:0]         out_rob_idx;
  logic [NUM_CDB_PORTS-1:0][DATA_WIDTH-1:0] out_data;
  logic [NUM_CDB_PORTS-1:0]                 out_ready;

  modport master (
    output in_valid, in_rob_idx, in_data, out_ready,
    input  in_ready, out_valid, out_rob_idx, out_data
  );

  modport slave (
    input  in_valid, in_rob_idx, in_data, out_ready,
    output in_ready, out_valid, out_rob_idx, out_data
  );
endinterface

// File: rtl/load_wb_queue.sv
// Load writeback queue: compacts MMU load results into a circular FIFO and drains them in order to CDB slots.
// Optional same-cycle bypass on an empty queue is enabled by defining LOAD_WB_BYPASS_EN.
module load_wb_queue #(
  parameter int unsigned NUM_LD_PORTS  = 2,
  parameter int unsigned NUM_CDB_PORTS = 1,
  parameter int unsigned QDEPTH        = 8,
  parameter int unsigned ROB_SIZE      = 16,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  load_wb_queue_if.slave          bus,
  output logic [$clog2(QDEPTH):0] count,
  output logic                    overflow_err
);
  localparam int unsigned RW   = $clog2(ROB_SIZE);
  localparam int unsigned PW   = $clog2(QDEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NCMP = (NUM_LD_PORTS > NUM_CDB_PORTS) ? NUM_LD_PORTS : NUM_CDB_PORTS;

  typedef struct packed {
    logic [RW-1:0]         rob_idx;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        r_mem [QDEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  entry_t        w_cmp [NCMP];
  logic [CW-1:0] w_nvalid;
  logic [CW-1:0] w_enq;
  logic [CW-1:0] w_deq;
  logic [CW-1:0] w_skip;
  logic [CW-1:0] w_pop;
  logic [CW-1:0] w_store;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_ovf;
  logic          w_byp;

  // Pack valid input ports into consecutive slots, lowest port first.
  always_comb begin
    int n;
    n = 0;
    for (int j = 0; j < NCMP; j++) w_cmp[j] = '0;
    for (int p = 0; p < NUM_LD_PORTS; p++) begin
      if (bus.in_valid[p]) begin
        for (int j = 0; j < NCMP; j++) begin
          if (n == j) w_cmp[j] = {bus.in_rob_idx[p], bus.in_data[p]};
        end
        n++;
      end
    end
    w_nvalid = CW'(n);
  end

  // Admission uses the registered count only; a same-cycle dequeue earns no credit.
  assign w_in_ready = (CW'(QDEPTH) - r_count) >= CW'(NUM_LD_PORTS);
  assign w_accept   = w_in_ready && !flush;
  assign w_enq      = w_accept ? w_nvalid : '0;
  assign w_ovf      = !flush && !w_in_ready && (|bus.in_valid);

`ifdef LOAD_WB_BYPASS_EN
  assign w_byp = (r_count == '0) && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // Bypassed entries consumed by the CDB never touch storage.
  assign w_skip  = w_byp ? w_deq : '0;
  assign w_pop   = w_byp ? '0 : w_deq;
  assign w_store = w_enq - w_skip;

  assign bus.in_ready = w_in_ready;
  assign count        = r_count;
  assign overflow_err = r_overflow;

  // Present head+k on slot k; dequeue stops at the first slot not taken.
  always_comb begin
    logic          go;
    logic          vld;
    logic [PW-1:0] idx;
    entry_t        ent;
    go              = 1'b1;
    vld             = 1'b0;
    idx             = '0;
    ent             = '0;
    w_deq           = '0;
    bus.out_valid   = '0;
    bus.out_rob_idx = '0;
    bus.out_data    = '0;
    for (int k = 0; k < NUM_CDB_PORTS; k++) begin
      idx = r_head + PW'(k);
      vld = !flush && (r_count > CW'(k));
      ent = r_mem[idx];
      if (w_byp) begin
        vld = w_enq > CW'(k);
        ent = w_cmp[k];
      end
      if (!vld) ent = '0;
      bus.out_valid[k]   = vld;
      bus.out_rob_idx[k] = ent.rob_idx;
      bus.out_data[k]    = ent.data;
      if (go && vld && bus.out_ready[k]) w_deq = w_deq + CW'(1);
      else                               go    = 1'b0;
    end
  end

  // Storage is not reset; entries are only read below the registered count.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int j = 0; j < NUM_LD_PORTS; j++) begin
        if ((CW'(j) >= w_skip) && (CW'(j) < w_enq))
          r_mem[r_tail + PW'(CW'(j) - w_skip)] <= w_cmp[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ovf) r_overflow <= 1'b1;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PW'(w_pop);
        r_tail  <= r_tail + PW'(w_store);
        r_count <= r_count + w_store - w_pop;
      end
    end
  end
endmodule

// File: tb/tb_load_wb_queue.sv
// Directed bench for load_wb_queue: reset, burst fill/drain, compaction, wrap, overflow, flush.
// Expected outputs come from hand-set constants plus a small in-order queue model.
module tb_load_wb_queue;
  localparam int unsigned NLD = 2;
  localparam int unsigned NCDB = 1;
  localparam int unsigned QD = 8;
  localparam int unsigned ROB = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] count;
  logic       overflow_err;

  load_wb_queue_if #(.NUM_LD_PORTS(NLD), .NUM_CDB_PORTS(NCDB), .RW(RW), .DATA_WIDTH(DW)) bus ();

  load_wb_queue #(
    .NUM_LD_PORTS(NLD), .NUM_CDB_PORTS(NCDB), .QDEPTH(QD), .ROB_SIZE(ROB), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [RW+DW-1:0] q[$];
  logic m_ovf;
  int tg;

  function automatic logic [DW-1:0] dval(input int t);
    return 32'hC0DE_0000 ^ (32'(t) * 32'h0001_1111);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cyc(input logic [1:0] v, input int t0, input int t1, input logic rdy, input logic fl);
    logic [RW+DW-1:0] in_q[$];
    logic [RW+DW-1:0] hd;
    int sz;
    logic ev;
    bus.in_valid      = v;
    bus.in_rob_idx[0] = RW'(t0);
    bus.in_rob_idx[1] = RW'(t1);
    bus.in_data[0]    = dval(t0);
    bus.in_data[1]    = dval(t1);
    bus.out_ready     = rdy;
    flush             = fl;
    #2;
    sz = q.size();
    check("count", 64'(count), 64'(sz));
    check("in_ready", bus.in_ready, sz <= int'(QD - NLD));
    check("overflow_err", overflow_err, m_ovf);
    if (v[0]) in_q.push_back({RW'(t0), dval(t0)});
    if (v[1]) in_q.push_back({RW'(t1), dval(t1)});
`ifdef LOAD_WB_BYPASS_EN
    if (sz == 0 && !fl) while (in_q.size() > 0) q.push_back(in_q.pop_front());
`endif
    ev = (q.size() > 0) && !fl;
    check("out_valid", bus.out_valid[0], ev);
    if (ev) begin
      hd = q[0];
      check("out_rob_idx", 64'(bus.out_rob_idx[0]), 64'(hd[RW+DW-1:DW]));
      check("out_data", 64'(bus.out_data[0]), 64'(hd[DW-1:0]));
    end
    if (fl) q.delete();
    else begin
      if (ev && rdy) void'(q.pop_front());
      if (sz <= int'(QD - NLD)) while (in_q.size() > 0) q.push_back(in_q.pop_front());
      else if (v != 2'b00) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = '0;
    bus.out_ready = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = '0;
    bus.in_rob_idx = '0;
    bus.in_data = '0;
    bus.out_ready = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid[0], 1'b0);
    check("rst_overflow", overflow_err, 1'b0);
    check("rst_out_rob_idx", 64'(bus.out_rob_idx[0]), 64'd0);
    check("rst_out_data", 64'(bus.out_data[0]), 64'd0);

    // Burst fill with CDB stalled, then drain in order.
    for (int i = 0; i < 4; i++) cyc(2'b11, 2 * i, 2 * i + 1, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 8; i++) cyc(2'b00, 0, 0, 1'b1, 1'b0);
    check("drained_count", 64'(count), 64'd0);

    // Port compaction: lone port 1 then lone port 0.
    cyc(2'b10, 15, 5, 1'b1, 1'b0);
    cyc(2'b01, 6, 15, 1'b1, 1'b0);
    cyc(2'b00, 0, 0, 1'b1, 1'b0);
    check("compact_empty", 64'(count), 64'd0);

    // Simultaneous enqueue/dequeue around count 6, wrapping the pointers.
    tg = 8;
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, tg, tg + 1, 1'b0, 1'b0);
      tg += 2;
    end
    for (int i = 0; i < 10; i++) begin
      if (q.size() <= int'(QD - NLD)) begin
        cyc(2'b11, tg, tg + 1, 1'b1, 1'b0);
        tg += 2;
      end else cyc(2'b00, 0, 0, 1'b1, 1'b0);
      if (i == 0) check("wrap_rise", 64'(count), 64'd7);
    end
    for (int i = 0; i < 10; i++) if (q.size() > 0) cyc(2'b00, 0, 0, 1'b1, 1'b0);
    check("wrap_drained", 64'(count), 64'd0);
    check("wrap_no_overflow", overflow_err, 1'b0);

    // Overflow at count 7; sticky through flush, cleared by reset.
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, tg, tg + 1, 1'b0, 1'b0);
      tg += 2;
    end
    cyc(2'b01, tg, 0, 1'b0, 1'b0);
    tg++;
    check("ovf_pre_count", 64'(count), 64'd7);
    cyc(2'b01, 14, 0, 1'b0, 1'b0);
    check("ovf_count", 64'(count), 64'd7);
    check("ovf_set", overflow_err, 1'b1);
    cyc(2'b00, 0, 0, 1'b0, 1'b1);
    cyc(2'b00, 0, 0, 1'b0, 1'b0);
    check("ovf_after_flush", overflow_err, 1'b1);
    pulse_reset();
    check("ovf_cleared", overflow_err, 1'b0);

    // Flush mid-drain with inputs present in the flush cycle.
    cyc(2'b11, 1, 2, 1'b0, 1'b0);
    cyc(2'b11, 3, 4, 1'b0, 1'b0);
    cyc(2'b01, 5, 0, 1'b0, 1'b0);
    check("flush_pre_count", 64'(count), 64'd5);
    cyc(2'b11, 12, 13, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    cyc(2'b01, 9, 0, 1'b1, 1'b0);
    cyc(2'b00, 0, 0, 1'b1, 1'b0);
    check("flush_ovf_unchanged", overflow_err, 1'b0);

`ifdef LOAD_WB_BYPASS_EN
    cyc(2'b01, 3, 0, 1'b1, 1'b0);
    check("bypass_count", 64'(count), 64'd0);
`endif
    cyc(2'b00, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
